trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Trap sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB with valid/ready_go handshakes). It watches the instruction in MEM and decides between a synchronous exception, an mret, or an asynchronous machine interrupt. It then kills MEM and all younger stages, drives the trap CSR updates (mepc, mcause, mstatus enter/return), and redirects IF to the handler or the return address. After a redirect it holds off further interrupts for a shadow window, so the refilled pipeline always makes forward progress.

Parameters:
SHADOW_CYCLES, 4, cycles after any redirect during which interrupts are not accepted (exceptions and mret still are)
CNT_W, 3, width of the shadow counter; must hold SHADOW_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_valid  in  1  MEM stage holds a valid instruction
mem_pc  in  32  PC of the MEM instruction
mem_excp  in  1  MEM instruction raised an exception
mem_excp_code  in  4  exception cause (0..15)
mem_is_mret  in  1  MEM instruction is mret
mstatus_mie  in  1  global interrupt enable
mie  in  3  {MEIE, MTIE, MSIE}
irq_ext  in  1  level external interrupt
irq_timer  in  1  level timer interrupt
irq_sw  in  1  level software interrupt
mtvec  in  32  trap vector; bits[1:0]=01 selects vectored mode
mepc_in  in  32  current mepc (mret target)
pipe_flush  out  1  kill MEM, EX, ID, IF contents; MEM must not commit
redirect_valid  out  1  one-cycle PC redirect strobe to IF
redirect_pc  out  32  redirect target
trap_enter  out  1  one-cycle: CSR file writes mepc/mcause; MPIE<=MIE, MIE<=0
trap_ret  out  1  one-cycle: CSR file sets MIE<=MPIE, MPIE<=1
mepc_wdata  out  32  value for mepc, valid with trap_enter
mcause_wdata  out  32  value for mcause, valid with trap_enter
busy  out  1  controller not in IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, shadow counter=0; all outputs 0.
- States: IDLE, TRAP, RET, SHADOW.
- Interrupt pending (combinational): mstatus_mie & |({irq_ext,irq_timer,irq_sw} & mie).
- Interrupt priority: external (cause 11) > software (3) > timer (7).
- IDLE, mem_valid=1, with the following priority (exception > mret > interrupt):
  - mem_excp=1: pipe_flush=1 this cycle (combinational). Latch mepc=mem_pc, mcause={1'b0,27'b0,mem_excp_code}. Go to TRAP.
  - mem_is_mret=1: pipe_flush=1 this cycle. Go to RET.
  - Interrupt pending: pipe_flush=1 this cycle; the MEM instruction is not committed. Latch mepc=mem_pc, mcause={1'b1,26'b0,cause[4:0]}. Go to TRAP.
  - Otherwise stay in IDLE.
- IDLE, mem_valid=0: no action; pending interrupts wait for the next valid MEM instruction.
- TRAP (exactly 1 cycle):
  - pipe_flush=1, trap_enter=1, redirect_valid=1; mepc_wdata/mcause_wdata driven from the latched values.
  - redirect_pc = {mtvec[31:2],2'b00}, plus 4*cause when the trap is an interrupt and mtvec[1:0]=01. Add modulo 2^32.
  - Next state: SHADOW, counter=SHADOW_CYCLES.
- RET (exactly 1 cycle): pipe_flush=1, trap_ret=1, redirect_valid=1, redirect_pc=mepc_in. Next state: SHADOW, counter=SHADOW_CYCLES.
- SHADOW:
  - Counter decrements each cycle; interrupts are ignored.
  - A valid MEM exception or mret is handled exactly as in IDLE (flush, then TRAP/RET); the shadow is not extended beyond the reload on that redirect.
  - When the counter reaches 0 with no event, go to IDLE.
  - SHADOW_CYCLES=0: go to IDLE directly after TRAP/RET.
- Simultaneous events: mem_excp together with mem_is_mret is treated as an exception. An interrupt asserted in the same cycle as an exception is left pending; it is taken only after the shadow window and only if MIE is set again.
- Outputs in TRAP/RET are registered-state decodes; pipe_flush in IDLE/SHADOW is combinational from the MEM inputs.
- busy=1 in TRAP, RET and SHADOW.
- Reset asserted in any state returns to IDLE immediately and drops all strobes.

Test Plan:
- Exception: mem_valid=1, mem_pc=0x0000_0040, mem_excp=1, code=2, mtvec=0x0000_0100 -> flush in cycle T. In T+1: trap_enter=1, mepc_wdata=0x40, mcause_wdata=0x0000_0002, redirect_pc=0x100. busy=1 for 1+4 cycles.
- Vectored interrupt: mstatus_mie=1, mie=3'b100, irq_ext=1, mem_pc=0x80, mtvec=0x0000_0201 -> mcause=0x8000_000B, redirect_pc=0x22C, mepc=0x80.
- mret: mem_is_mret=1, mepc_in=0x0000_0084 -> flush in T. In T+1: trap_ret=1, redirect_pc=0x84, trap_enter=0.
- Priority: irq_ext, irq_timer and mem_excp (code 11) together -> exception cause 0x0000_000B is taken. irq_timer held with mie=3'b010 and MIE re-set -> timer trap (0x8000_0007) occurs only after the 4-cycle shadow.
- Gating: irq_sw=1 with mstatus_mie=0, or with mem_valid=0 -> no flush/redirect. Asserting mem_valid=1 with MIE=1 -> trap in the next cycle.
- Reset in TRAP: rst_n low mid-cycle -> all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer choosing exception / mret / interrupt at MEM, flushing and redirecting the pipeline
module trap_ctrl #(
   parameter int SHADOW_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_excp,
   input  logic [3:0]  mem_excp_code,
   input  logic        mem_is_mret,
   input  logic        mstatus_mie,
   input  logic [2:0]  mie,
   input  logic        irq_ext,
   input  logic        irq_timer,
   input  logic        irq_sw,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc_in,
   output logic        pipe_flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        trap_enter,
   output logic        trap_ret,
   output logic [31:0] mepc_wdata,
   output logic [31:0] mcause_wdata,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, TRAP, RET, SHADOW} state_t;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SHADOW_CYCLES);
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0]      mepc_q, mcause_q, vec_off;
   logic [2:0]       irq_act;
   logic [4:0]       irq_cause;
   logic             irq_pend, open, take_excp, take_ret, take_irq;

   assign irq_act   = {irq_ext, irq_timer, irq_sw} & mie;
   assign irq_pend  = mstatus_mie & |irq_act;
   assign irq_cause = irq_act[2] ? 5'd11 : irq_act[0] ? 5'd3 : 5'd7;
   assign open      = (state == IDLE) || (state == SHADOW);
   assign take_excp = open & mem_valid & mem_excp;
   assign take_ret  = open & mem_valid & mem_is_mret & ~mem_excp;
   // interrupts are only taken from IDLE so the shadow window guarantees forward progress
   assign take_irq  = (state == IDLE) & mem_valid & ~mem_excp & ~mem_is_mret & irq_pend;

   // next state and shadow counter
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (take_excp || take_irq) begin
         state_n = TRAP;
      end else if (take_ret) begin
         state_n = RET;
      end else if (state == TRAP || state == RET) begin
         state_n = (SHADOW_CYCLES == 0) ? IDLE : SHADOW;
         cnt_n   = RELOAD;
      end else if (state == SHADOW) begin
         cnt_n   = cnt - 1'b1;
         state_n = (cnt <= CNT_W'(1)) ? IDLE : SHADOW;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // capture mepc/mcause when a trap is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mepc_q   <= '0;
         mcause_q <= '0;
      end else if (take_excp || take_irq) begin
         mepc_q   <= mem_pc;
         mcause_q <= take_excp ? {28'b0, mem_excp_code} : {1'b1, 26'b0, irq_cause};
      end
   end

   assign trap_enter     = (state == TRAP);
   assign trap_ret       = (state == RET);
   assign redirect_valid = trap_enter | trap_ret;
   assign busy           = (state != IDLE);
   // flush is combinational from MEM while deciding, so gate it with reset to keep outputs quiet
   assign pipe_flush     = rst_n & (take_excp | take_ret | take_irq | redirect_valid);
   assign vec_off        = (mcause_q[31] && mtvec[1:0] == 2'b01) ? {25'b0, mcause_q[4:0], 2'b00} : 32'b0;
   assign redirect_pc    = trap_enter ? {mtvec[31:2], 2'b00} + vec_off : trap_ret ? mepc_in : 32'b0;
   assign mepc_wdata     = trap_enter ? mepc_q : 32'b0;
   assign mcause_wdata   = trap_enter ? mcause_q : 32'b0;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven and directed checks of the trap sequencer
module tb_trap_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid, mem_excp, mem_is_mret, mstatus_mie, irq_ext, irq_timer, irq_sw;
   logic [31:0] mem_pc, mtvec, mepc_in;
   logic [3:0]  mem_excp_code;
   logic [2:0]  mie;
   logic        pipe_flush, redirect_valid, trap_enter, trap_ret, busy;
   logic [31:0] redirect_pc, mepc_wdata, mcause_wdata;
   int          n_chk = 0;
   int          n_fail = 0;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        excp;
      logic [3:0]  code;
      logic        mret;
      logic        mmie;
      logic [2:0]  mie;
      logic        ext, tim, sw;
      logic [31:0] mtvec, mepc_in;
      logic        flush, rv;
      logic [31:0] rpc;
      logic        te, tr;
      logic [31:0] mepc_w, mcause_w;
   } vec_t;
   vec_t vecs[15];

   trap_ctrl #(.SHADOW_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_excp(mem_excp),
      .mem_excp_code(mem_excp_code), .mem_is_mret(mem_is_mret), .mstatus_mie(mstatus_mie),
      .mie(mie), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw), .mtvec(mtvec),
      .mepc_in(mepc_in), .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .trap_enter(trap_enter), .trap_ret(trap_ret),
      .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      mem_valid = 0; mem_excp = 0; mem_is_mret = 0; mem_excp_code = 0;
      irq_ext = 0; irq_timer = 0; irq_sw = 0;
   endtask

   task automatic clear_all();
      clear_events();
      mem_pc = 0; mstatus_mie = 0; mie = 0; mtvec = 0; mepc_in = 0;
   endtask

   task automatic settle(input int idx);
      clear_all();
      repeat (6) cyc();
      #1;
      chk("idle_busy", idx, 32'(busy), 0);
   endtask

   task automatic wait_idle(input int idx, input int exp_n);
      int n = 0;
      while (busy && n < 20) begin
         n++;
         cyc();
      end
      chk("busy_len", idx, n, exp_n);
   endtask

   task automatic run_vec(input int i);
      mem_valid = vecs[i].v; mem_pc = vecs[i].pc; mem_excp = vecs[i].excp;
      mem_excp_code = vecs[i].code; mem_is_mret = vecs[i].mret; mstatus_mie = vecs[i].mmie;
      mie = vecs[i].mie; irq_ext = vecs[i].ext; irq_timer = vecs[i].tim; irq_sw = vecs[i].sw;
      mtvec = vecs[i].mtvec; mepc_in = vecs[i].mepc_in;
      #1;
      chk("flush", i, 32'(pipe_flush), 32'(vecs[i].flush));
      cyc();
      clear_events();
      #1;
      chk("redirect_valid", i, 32'(redirect_valid), 32'(vecs[i].rv));
      chk("redirect_pc", i, redirect_pc, vecs[i].rpc);
      chk("trap_enter", i, 32'(trap_enter), 32'(vecs[i].te));
      chk("trap_ret", i, 32'(trap_ret), 32'(vecs[i].tr));
      chk("mepc_wdata", i, mepc_wdata, vecs[i].mepc_w);
      chk("mcause_wdata", i, mcause_wdata, vecs[i].mcause_w);
      chk("busy", i, 32'(busy), 32'(vecs[i].rv));
      settle(i);
   endtask

   initial begin
      //        v  pc      ex code mr mm mie    e  t  s  mtvec          mepc_in  fl rv rpc            te tr mepc_w   mcause_w
      vecs[0]  = '{1, 32'h40, 1, 2,  0, 0, 3'b000, 0, 0, 0, 32'h100,       32'h0,   1, 1, 32'h100,       1, 0, 32'h40, 32'h2};
      vecs[1]  = '{1, 32'h80, 0, 0,  0, 1, 3'b100, 1, 0, 0, 32'h201,       32'h0,   1, 1, 32'h22C,       1, 0, 32'h80, 32'h8000000B};
      vecs[2]  = '{1, 32'h50, 0, 0,  1, 0, 3'b000, 0, 0, 0, 32'h100,       32'h84,  1, 1, 32'h84,        0, 1, 32'h0,  32'h0};
      vecs[3]  = '{1, 32'h60, 1, 11, 0, 1, 3'b111, 1, 1, 0, 32'h201,       32'h0,   1, 1, 32'h200,       1, 0, 32'h60, 32'hB};
      vecs[4]  = '{1, 32'h64, 0, 0,  0, 0, 3'b001, 0, 0, 1, 32'h100,       32'h0,   0, 0, 32'h0,         0, 0, 32'h0,  32'h0};
      vecs[5]  = '{0, 32'h68, 0, 0,  0, 1, 3'b001, 0, 0, 1, 32'h100,       32'h0,   0, 0, 32'h0,         0, 0, 32'h0,  32'h0};
      vecs[6]  = '{1, 32'h90, 0, 0,  0, 1, 3'b010, 0, 1, 0, 32'h300,       32'h0,   1, 1, 32'h300,       1, 0, 32'h90, 32'h80000007};
      vecs[7]  = '{1, 32'hA0, 0, 0,  0, 1, 3'b001, 0, 0, 1, 32'h401,       32'h0,   1, 1, 32'h40C,       1, 0, 32'hA0, 32'h80000003};
      vecs[8]  = '{1, 32'hB0, 0, 0,  0, 1, 3'b111, 1, 1, 1, 32'h201,       32'h0,   1, 1, 32'h22C,       1, 0, 32'hB0, 32'h8000000B};
      vecs[9]  = '{1, 32'hB4, 0, 0,  0, 1, 3'b011, 0, 1, 1, 32'h201,       32'h0,   1, 1, 32'h20C,       1, 0, 32'hB4, 32'h80000003};
      vecs[10] = '{1, 32'hC0, 1, 5,  1, 0, 3'b000, 0, 0, 0, 32'h100,       32'h88,  1, 1, 32'h100,       1, 0, 32'hC0, 32'h5};
      vecs[11] = '{1, 32'hC4, 0, 0,  0, 1, 3'b011, 1, 0, 0, 32'h100,       32'h0,   0, 0, 32'h0,         0, 0, 32'h0,  32'h0};
      vecs[12] = '{1, 32'hD0, 0, 0,  0, 1, 3'b100, 1, 0, 0, 32'hFFFFFFFD,  32'h0,   1, 1, 32'h28,        1, 0, 32'hD0, 32'h8000000B};
      vecs[13] = '{1, 32'hD4, 0, 0,  0, 1, 3'b100, 1, 0, 0, 32'h203,       32'h0,   1, 1, 32'h200,       1, 0, 32'hD4, 32'h8000000B};
      vecs[14] = '{1, 32'hD8, 0, 0,  1, 1, 3'b100, 1, 0, 0, 32'h201,       32'h9C,  1, 1, 32'h9C,        0, 1, 32'h0,  32'h0};

      rst_n = 0;
      clear_all();
      #3;
      chk("rst_flush", 0, 32'(pipe_flush), 0);
      chk("rst_rv", 0, 32'(redirect_valid), 0);
      chk("rst_te", 0, 32'(trap_enter), 0);
      chk("rst_tr", 0, 32'(trap_ret), 0);
      chk("rst_busy", 0, 32'(busy), 0);
      chk("rst_rpc", 0, redirect_pc, 0);
      cyc();
      rst_n = 1;
      cyc();

      for (int i = 0; i < 15; i++) run_vec(i);

      // busy spans the TRAP cycle plus the 4-cycle shadow
      mem_valid = 1; mem_pc = 32'h40; mem_excp = 1; mem_excp_code = 2; mtvec = 32'h100;
      cyc();
      clear_events();
      wait_idle(100, 5);
      settle(100);

      // exception beats simultaneous interrupts; held timer waits out the shadow
      mem_valid = 1; mem_pc = 32'h30; mem_excp = 1; mem_excp_code = 11;
      irq_ext = 1; irq_timer = 1; mie = 3'b110; mstatus_mie = 1; mtvec = 32'h100;
      #1;
      chk("pri_flush", 101, 32'(pipe_flush), 1);
      cyc();
      mem_excp = 0; mem_excp_code = 0; irq_ext = 0; mie = 3'b010; mem_pc = 32'h44;
      #1;
      chk("pri_mcause", 101, mcause_wdata, 32'hB);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("shadow_flush", 102 + k, 32'(pipe_flush), 0);
         chk("shadow_busy", 102 + k, 32'(busy), 1);
      end
      cyc();
      chk("post_shadow_flush", 106, 32'(pipe_flush), 1);
      cyc();
      clear_events();
      #1;
      chk("timer_te", 107, 32'(trap_enter), 1);
      chk("timer_mcause", 107, mcause_wdata, 32'h80000007);
      chk("timer_mepc", 107, mepc_wdata, 32'h44);
      chk("timer_rpc", 107, redirect_pc, 32'h100);
      settle(107);

      // interrupt waits for a valid MEM instruction
      mstatus_mie = 1; mie = 3'b001; irq_sw = 1; mtvec = 32'h100;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("novalid_flush", 110 + k, 32'(pipe_flush), 0);
         chk("novalid_busy", 110 + k, 32'(busy), 0);
         cyc();
      end
      mem_valid = 1; mem_pc = 32'h70;
      #1;
      chk("valid_flush", 112, 32'(pipe_flush), 1);
      cyc();
      clear_events();
      #1;
      chk("sw_te", 112, 32'(trap_enter), 1);
      chk("sw_mcause", 112, mcause_wdata, 32'h80000003);
      settle(112);

      // mret accepted inside the shadow reloads it once
      mem_valid = 1; mem_pc = 32'h10; mem_excp = 1; mem_excp_code = 4; mtvec = 32'h100;
      cyc();
      clear_events();
      cyc();
      cyc();
      mem_valid = 1; mem_is_mret = 1; mepc_in = 32'h84;
      #1;
      chk("shadow_mret_flush", 120, 32'(pipe_flush), 1);
      cyc();
      clear_events();
      #1;
      chk("shadow_mret_tr", 121, 32'(trap_ret), 1);
      chk("shadow_mret_rpc", 121, redirect_pc, 32'h84);
      wait_idle(121, 5);
      settle(121);

      // asynchronous reset while in TRAP
      mem_valid = 1; mem_pc = 32'h20; mem_excp = 1; mem_excp_code = 3; mtvec = 32'h100;
      cyc();
      #1;
      chk("pre_rst_te", 130, 32'(trap_enter), 1);
      rst_n = 0;
      #1;
      chk("mid_rst_te", 131, 32'(trap_enter), 0);
      chk("mid_rst_rv", 131, 32'(redirect_valid), 0);
      chk("mid_rst_flush", 131, 32'(pipe_flush), 0);
      chk("mid_rst_busy", 131, 32'(busy), 0);
      chk("mid_rst_rpc", 131, redirect_pc, 0);
      chk("mid_rst_mcause", 131, mcause_wdata, 0);
      clear_all();
      cyc();
      rst_n = 1;
      cyc();
      chk("post_rst_busy", 132, 32'(busy), 0);
      chk("post_rst_flush", 132, 32'(pipe_flush), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
